// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the branch predictor slice.
package bp_pkg;

  // Tags are stored zero-extended to the widest possible tag (IDX_W >= 0),
  // so the entry layout does not depend on the BTB size parameter.
  localparam int TAG_W = 30;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weak not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weak taken

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_rec_t;

  // 2-bit saturating counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch / resolve / recovery bundle between the pipeline and the predictor.
// Handshake: no ready/valid back-pressure on this bundle; fetch_valid and
// resolve_valid qualify their payloads for exactly the cycle they are high,
// and fetch_hold is the only flow control (fetch must stall while it is 1).
interface branch_predict_unit_if;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        stall;
  logic        flush;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        branch_predict;
  logic [31:0] branch_pc;
  logic        branch_undo;
  logic [31:0] pc_not_taken;
  logic        fetch_hold;

  modport master (
    output fetch_pc, fetch_valid, stall, flush,
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  branch_predict, branch_pc, branch_undo, pc_not_taken, fetch_hold
  );

  modport slave (
    input  fetch_pc, fetch_valid, stall, flush,
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output branch_predict, branch_pc, branch_undo, pc_not_taken, fetch_hold
  );
endinterface

// File: rtl/branch_predict_unit_pred_fifo.sv
// Synchronous FIFO of in-flight prediction records; clear empties it.
module pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  pred_rec_t wdata,
  output pred_rec_t head,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);

  pred_rec_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push_ok, pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer/count state; reset and clear both empty the FIFO and win over push/pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage; contents of empty slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB predictor with in-flight checking and mispredict recovery.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int ENTRIES    = 16,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  branch_predict_unit_if.slave bus
);
  btb_entry_t       btb [ENTRIES];
  logic [IDX_W-1:0] idx_f, idx_r;
  btb_entry_t       ent_f, ent_r;
  logic             hit_f, hit_r;
  pred_rec_t        head, push_rec;
  logic             fifo_full, fifo_empty;
  logic             head_match, mispredict, undo_d;
  logic             push, pop, clear;
  logic             undo_q;
  logic [31:0]      pnt_q;

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

  // Lookup and resolve-side comparisons, all from registered state.
  always_comb begin
    idx_f      = bus.fetch_pc[IDX_W+1:2];
    ent_f      = btb[idx_f];
    hit_f      = ent_f.valid && (ent_f.tag == tag_of(bus.fetch_pc));
    idx_r      = bus.resolve_pc[IDX_W+1:2];
    ent_r      = btb[idx_r];
    hit_r      = ent_r.valid && (ent_r.tag == tag_of(bus.resolve_pc));
    head_match = !fifo_empty && (head.pc == bus.resolve_pc);
    if (head_match)
      mispredict = (head.pred_taken != bus.resolve_taken) ||
                   (bus.resolve_taken && (head.pred_target != bus.resolve_target));
    else
      mispredict = bus.resolve_taken;  // untracked branch counts as predicted not-taken
    undo_d   = bus.resolve_valid && mispredict && !bus.flush;
    push     = bus.fetch_valid && hit_f && !bus.stall && !fifo_full && !undo_q && !bus.flush;
    pop      = bus.resolve_valid && head_match;
    clear    = bus.flush || undo_d;
    push_rec = '{pc: bus.fetch_pc, pred_taken: ent_f.ctr[1], pred_target: ent_f.target};
  end

  assign bus.branch_predict = bus.fetch_valid && hit_f && ent_f.ctr[1] && !undo_q;
  assign bus.branch_pc      = hit_f ? ent_f.target : 32'h0;
  assign bus.branch_undo    = undo_q;
  assign bus.pc_not_taken   = pnt_q;
  assign bus.fetch_hold     = fifo_full;

  pred_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (push_rec),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One-cycle undo pulse with the recovery PC captured alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      undo_q <= 1'b0;
      pnt_q  <= 32'h0;
    end else begin
      undo_q <= undo_d;
      if (undo_d) pnt_q <= bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
    end
  end

  // BTB training on every resolve; allocation only for taken misses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        btb[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, ctr: CTR_RESET};
    end else if (bus.resolve_valid) begin
      if (hit_r) begin
        btb[idx_r].ctr <= ctr_next(ent_r.ctr, bus.resolve_taken);
        if (bus.resolve_taken) btb[idx_r].target <= bus.resolve_target;
      end else if (bus.resolve_taken) begin
        btb[idx_r] <= '{valid: 1'b1, tag: tag_of(bus.resolve_pc),
                        target: bus.resolve_target, ctr: CTR_ALLOC};
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit.
module tb_branch_predict_unit;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  branch_predict_unit_if bus ();

  branch_predict_unit #(.ENTRIES(16), .IDX_W(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_pc       = 32'h0;
    bus.fetch_valid    = 1'b0;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.resolve_valid  = 1'b0;
    bus.resolve_pc     = 32'h0;
    bus.resolve_taken  = 1'b0;
    bus.resolve_target = 32'h0;
  endtask

  // Present a lookup without pushing (stall) and let combinational outputs settle.
  task automatic peek(input logic [31:0] pc);
    bus.fetch_pc    = pc;
    bus.fetch_valid = 1'b1;
    bus.stall       = 1'b1;
    #1;
  endtask

  task automatic do_resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.resolve_valid  = 1'b1;
    bus.resolve_pc     = pc;
    bus.resolve_taken  = taken;
    bus.resolve_target = tgt;
    cyc();
    bus.resolve_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL reset_undo: got %b want 0", bus.branch_undo); fails++; end
    tests++; if (bus.pc_not_taken !== 32'h0) begin $display("FAIL reset_pnt: got %h want 0", bus.pc_not_taken); fails++; end
    tests++; if (bus.fetch_hold !== 1'b0) begin $display("FAIL reset_hold: got %b want 0", bus.fetch_hold); fails++; end
    peek(32'h100);
    tests++; if (bus.branch_predict !== 1'b0) begin $display("FAIL reset_predict: got %b want 0", bus.branch_predict); fails++; end
    tests++; if (bus.branch_pc !== 32'h0) begin $display("FAIL reset_bpc: got %h want 0", bus.branch_pc); fails++; end
    idle();
  endtask

  task automatic test_allocate();
    do_resolve(32'h100, 1'b1, 32'h200);
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL alloc_undo: got %b want 1", bus.branch_undo); fails++; end
    tests++; if (bus.pc_not_taken !== 32'h200) begin $display("FAIL alloc_pnt: got %h want 200", bus.pc_not_taken); fails++; end
    cyc();
    tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL alloc_undo_pulse: got %b want 0", bus.branch_undo); fails++; end
    peek(32'h100);
    tests++; if (bus.branch_predict !== 1'b1) begin $display("FAIL alloc_predict: got %b want 1", bus.branch_predict); fails++; end
    tests++; if (bus.branch_pc !== 32'h200) begin $display("FAIL alloc_bpc: got %h want 200", bus.branch_pc); fails++; end
    idle();
  endtask

  // ctr 10 -> 11, push a taken prediction, resolve not-taken.
  task automatic test_mispredict_nt();
    do_resolve(32'h100, 1'b1, 32'h200);
    cyc();
    bus.fetch_pc = 32'h100; bus.fetch_valid = 1'b1;
    #1;
    tests++; if (bus.branch_predict !== 1'b1) begin $display("FAIL nt_predict_strong: got %b want 1", bus.branch_predict); fails++; end
    cyc();
    idle();
    do_resolve(32'h100, 1'b0, 32'h0);
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL nt_undo: got %b want 1", bus.branch_undo); fails++; end
    tests++; if (bus.pc_not_taken !== 32'h104) begin $display("FAIL nt_pnt: got %h want 104", bus.pc_not_taken); fails++; end
    cyc();
    tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL nt_undo_pulse: got %b want 0", bus.branch_undo); fails++; end
    peek(32'h100);
    tests++; if (bus.branch_predict !== 1'b1) begin $display("FAIL nt_predict_weak: got %b want 1", bus.branch_predict); fails++; end
    idle();
    // FIFO must be empty: this taken resolve is untracked, so it mispredicts.
    do_resolve(32'h100, 1'b1, 32'h200);
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL nt_fifo_empty: got %b want 1", bus.branch_undo); fails++; end
    cyc();
  endtask

  // Push of 0x100 coincides with a mispredicting resolve of 0x304.
  task automatic test_push_mispredict();
    bus.fetch_pc = 32'h100; bus.fetch_valid = 1'b1;
    bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h304; bus.resolve_taken = 1'b1; bus.resolve_target = 32'h400;
    cyc();
    idle();
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL pm_undo: got %b want 1", bus.branch_undo); fails++; end
    tests++; if (bus.pc_not_taken !== 32'h400) begin $display("FAIL pm_pnt: got %h want 400", bus.pc_not_taken); fails++; end
    cyc();
    tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL pm_undo_pulse: got %b want 0", bus.branch_undo); fails++; end
    // Dropped push means 0x100 is untracked and mispredicts.
    do_resolve(32'h100, 1'b1, 32'h200);
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL pm_push_dropped: got %b want 1", bus.branch_undo); fails++; end
    cyc();
    peek(32'h304);
    tests++; if (bus.branch_predict !== 1'b1) begin $display("FAIL pm_alloc_predict: got %b want 1", bus.branch_predict); fails++; end
    tests++; if (bus.branch_pc !== 32'h400) begin $display("FAIL pm_alloc_bpc: got %h want 400", bus.branch_pc); fails++; end
    idle();
  endtask

  task automatic test_flush();
    bus.fetch_pc = 32'h100; bus.fetch_valid = 1'b1;
    cyc();
    idle();
    bus.flush = 1'b1;
    do_resolve(32'h304, 1'b1, 32'h400);
    bus.flush = 1'b0;
    tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL flush_no_undo: got %b want 0", bus.branch_undo); fails++; end
    do_resolve(32'h100, 1'b1, 32'h200);
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL flush_cleared: got %b want 1", bus.branch_undo); fails++; end
    cyc();
    peek(32'h100);
    tests++; if (bus.branch_pc !== 32'h200) begin $display("FAIL flush_btb_kept: got %h want 200", bus.branch_pc); fails++; end
    idle();
  endtask

  task automatic test_full();
    bus.fetch_pc = 32'h100; bus.fetch_valid = 1'b1;
    repeat (4) cyc();
    tests++; if (bus.fetch_hold !== 1'b1) begin $display("FAIL full_hold: got %b want 1", bus.fetch_hold); fails++; end
    cyc();
    idle();
    tests++; if (bus.fetch_hold !== 1'b1) begin $display("FAIL full_hold_fifth: got %b want 1", bus.fetch_hold); fails++; end
    do_resolve(32'h100, 1'b1, 32'h200);
    tests++; if (bus.fetch_hold !== 1'b0) begin $display("FAIL full_pop_hold: got %b want 0", bus.fetch_hold); fails++; end
    tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL full_pop_undo: got %b want 0", bus.branch_undo); fails++; end
    for (int i = 0; i < 3; i++) begin
      do_resolve(32'h100, 1'b1, 32'h200);
      tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL full_drain_%0d: got %b want 0", i, bus.branch_undo); fails++; end
    end
    // Exactly four records were held; the fifth fetch was never pushed.
    do_resolve(32'h100, 1'b1, 32'h200);
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL full_fifth_dropped: got %b want 1", bus.branch_undo); fails++; end
    cyc();
  endtask

  // Counter is at 11 after many taken resolves; two not-taken steps reach 01.
  task automatic test_saturation();
    peek(32'h100);
    tests++; if (bus.branch_predict !== 1'b1) begin $display("FAIL sat_hold_11: got %b want 1", bus.branch_predict); fails++; end
    idle();
    do_resolve(32'h100, 1'b0, 32'h0);
    tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL sat_nt_no_undo: got %b want 0", bus.branch_undo); fails++; end
    peek(32'h100);
    tests++; if (bus.branch_predict !== 1'b1) begin $display("FAIL sat_ctr_10: got %b want 1", bus.branch_predict); fails++; end
    idle();
    do_resolve(32'h100, 1'b0, 32'h0);
    peek(32'h100);
    tests++; if (bus.branch_predict !== 1'b0) begin $display("FAIL sat_ctr_01: got %b want 0", bus.branch_predict); fails++; end
    tests++; if (bus.branch_pc !== 32'h200) begin $display("FAIL sat_bpc_hit: got %h want 200", bus.branch_pc); fails++; end
    idle();
  endtask

  task automatic test_wrap();
    do_resolve(32'hFFFF_FFFC, 1'b1, 32'h40);
    tests++; if (bus.pc_not_taken !== 32'h40) begin $display("FAIL wrap_alloc_pnt: got %h want 40", bus.pc_not_taken); fails++; end
    cyc();
    bus.fetch_pc = 32'hFFFF_FFFC; bus.fetch_valid = 1'b1;
    cyc();
    idle();
    do_resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL wrap_undo: got %b want 1", bus.branch_undo); fails++; end
    tests++; if (bus.pc_not_taken !== 32'h0) begin $display("FAIL wrap_pnt: got %h want 0", bus.pc_not_taken); fails++; end
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.fetch_pc = 32'h304; bus.fetch_valid = 1'b1;
    cyc();
    idle();
    rst = 1'b1;
    bus.resolve_valid = 1'b1; bus.resolve_pc = 32'h500; bus.resolve_taken = 1'b1; bus.resolve_target = 32'h600;
    cyc();
    rst = 1'b0;
    idle();
    tests++; if (bus.branch_undo !== 1'b0) begin $display("FAIL rmid_undo: got %b want 0", bus.branch_undo); fails++; end
    tests++; if (bus.pc_not_taken !== 32'h0) begin $display("FAIL rmid_pnt: got %h want 0", bus.pc_not_taken); fails++; end
    tests++; if (bus.fetch_hold !== 1'b0) begin $display("FAIL rmid_hold: got %b want 0", bus.fetch_hold); fails++; end
    peek(32'h304);
    tests++; if (bus.branch_predict !== 1'b0) begin $display("FAIL rmid_predict_304: got %b want 0", bus.branch_predict); fails++; end
    tests++; if (bus.branch_pc !== 32'h0) begin $display("FAIL rmid_bpc_304: got %h want 0", bus.branch_pc); fails++; end
    peek(32'h100);
    tests++; if (bus.branch_pc !== 32'h0) begin $display("FAIL rmid_bpc_100: got %h want 0", bus.branch_pc); fails++; end
    idle();
    do_resolve(32'h304, 1'b1, 32'h400);
    tests++; if (bus.branch_undo !== 1'b1) begin $display("FAIL rmid_fifo_empty: got %b want 1", bus.branch_undo); fails++; end
    cyc();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_allocate();
    test_mispredict_nt();
    test_push_mispredict();
    test_flush();
    test_full();
    test_saturation();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
